// File: rtl/ll_req_resp_responder.sv
// Responder end of the linked-list req/resp protocol: checks host requests against
// list occupancy and forwards legal ones to ll_ctrl. Define LL_INTF_TIMEOUT_EN for the ctrl watchdog.
module ll_req_resp_responder #(
  parameter int PTR_WD      = 4,
  parameter int WR_DATA_WD  = 8,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_vld,
  input  logic [2:0]            req_type,
  input  logic [PTR_WD-1:0]     req_pos,
  input  logic [WR_DATA_WD-1:0] req_data,
  input  logic                  resp_taken,
  output logic                  intf_ready,
  output logic                  resp_vld,
  output logic                  resp_type,
  output logic [WR_DATA_WD-1:0] resp_data,
  output logic                  resp_data_vld,
  output logic                  ctrl_req_vld,
  output logic [2:0]            ctrl_req_type,
  output logic [PTR_WD-1:0]     ctrl_req_pos,
  output logic [WR_DATA_WD-1:0] ctrl_req_data,
  input  logic                  ctrl_req_rdy,
  input  logic                  ctrl_done,
  input  logic [WR_DATA_WD-1:0] ctrl_rd_data,
  output logic [PTR_WD:0]       occupancy
);

  // state   | meaning
  // S_IDLE  | waiting for a host request, intf_ready high
  // S_CHECK | legality check of the captured request against occupancy
  // S_ISSUE | command held on ctrl_req_* until ctrl_req_rdy
  // S_WAIT  | waiting for ctrl_done (or watchdog expiry when built in)
  // S_RESP  | response held until resp_taken
  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_ISSUE, S_WAIT, S_RESP} state_t;

  localparam int             DEPTH    = 2 ** PTR_WD;
  localparam logic [PTR_WD:0] OCC_FULL = (PTR_WD + 1)'(DEPTH);

  state_t                state, state_nxt;
  logic [2:0]            cap_type;
  logic [PTR_WD-1:0]     cap_pos;
  logic [WR_DATA_WD-1:0] cap_data;
  logic                  resp_err;
  logic                  resp_dvld;
  logic [WR_DATA_WD-1:0] resp_dat;
  logic                  is_push, is_pop, is_posop, is_dec, chk_err;
  logic                  wd_expired;

  assign is_push  = (cap_type == 3'd0) || (cap_type == 3'd1);
  assign is_pop   = (cap_type == 3'd2) || (cap_type == 3'd3);
  assign is_posop = (cap_type == 3'd4) || (cap_type == 3'd5);
  assign is_dec   = is_pop || (cap_type == 3'd5);

  assign chk_err = (cap_type > 3'd5)
                || (is_push  && (occupancy == OCC_FULL))
                || (is_pop   && (occupancy == '0))
                || (is_posop && ({1'b0, cap_pos} >= occupancy));

`ifdef LL_INTF_TIMEOUT_EN
  localparam int                WD_WD   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_WD-1:0] WD_LOAD = WD_WD'(TIMEOUT_CYC - 1);
  logic [WD_WD-1:0] wd_cnt;

  // Down-counter loaded on WAIT entry; terminal count flags expiry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      wd_cnt <= '0;
    else if (state == S_ISSUE && ctrl_req_rdy)
      wd_cnt <= WD_LOAD;
    else if (state == S_WAIT && wd_cnt != '0)
      wd_cnt <= wd_cnt - WD_WD'(1);
  end

  assign wd_expired = (state == S_WAIT) && (wd_cnt == '0);
`else
  assign wd_expired = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (req_vld)                  state_nxt = S_CHECK;
      S_CHECK: state_nxt = chk_err ? S_RESP : S_ISSUE;
      S_ISSUE: if (ctrl_req_rdy)             state_nxt = S_WAIT;
      S_WAIT:  if (ctrl_done || wd_expired)  state_nxt = S_RESP;
      S_RESP:  if (resp_taken)               state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    intf_ready   = (state == S_IDLE);
    ctrl_req_vld = (state == S_ISSUE);
    resp_vld     = (state == S_RESP);
  end

  assign ctrl_req_type = cap_type;
  assign ctrl_req_pos  = cap_pos;
  assign ctrl_req_data = cap_data;
  assign resp_type     = resp_err;
  assign resp_data     = resp_dat;
  assign resp_data_vld = resp_dvld;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cap_type <= '0;
      cap_pos  <= '0;
      cap_data <= '0;
    end else if (state == S_IDLE && req_vld) begin
      cap_type <= req_type;
      cap_pos  <= req_pos;
      cap_data <= req_data;
    end
  end

  // Response fields are zero outside RESP so resp_data reads 0 whenever it is not meaningful.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      resp_err  <= 1'b0;
      resp_dvld <= 1'b0;
      resp_dat  <= '0;
    end else begin
      case (state)
        S_CHECK: begin
          resp_err  <= chk_err;
          resp_dvld <= 1'b0;
          resp_dat  <= '0;
        end
        S_WAIT: begin
          if (ctrl_done) begin
            resp_err  <= 1'b0;
            resp_dvld <= !is_push;
            resp_dat  <= is_push ? '0 : ctrl_rd_data;
          end else if (wd_expired) begin
            resp_err  <= 1'b1;
          end
        end
        S_RESP: begin
          if (resp_taken) begin
            resp_err  <= 1'b0;
            resp_dvld <= 1'b0;
            resp_dat  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      occupancy <= '0;
    else if (state == S_WAIT && ctrl_done) begin
      if (is_push && occupancy != OCC_FULL)
        occupancy <= occupancy + (PTR_WD + 1)'(1);
      else if (is_dec && occupancy != '0)
        occupancy <= occupancy - (PTR_WD + 1)'(1);
    end
  end

endmodule
